// File: rtl/kofn_persist_detector.sv
// K-of-N vote detector: popcount of a valid sample compared against a runtime
// target (exact / at-least / at-most), qualified by a consecutive-match run counter.
module kofn_persist_detector #(
  parameter int N  = 5,
  parameter int CW = $clog2(N+1),
  parameter int HW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_vec,
  input  logic          in_valid,
  input  logic [CW-1:0] k_target,
  input  logic [1:0]    mode,
  input  logic [HW-1:0] hold_cycles,
  input  logic          clear_sticky,
  output logic [CW-1:0] count_out,
  output logic          match_out,
  output logic          match_valid,
  output logic          match_seen
);

  localparam logic [1:0] MODE_EXACT   = 2'b00;
  localparam logic [1:0] MODE_ATLEAST = 2'b01;
  localparam logic [1:0] MODE_ATMOST  = 2'b10;

  logic [CW-1:0] pop_d;
  logic [CW-1:0] cnt1_q;
  logic          v1_q;
  logic [HW-1:0] run_q, run_d;
  logic [CW-1:0] count_q;
  logic          match_q, match_d;
  logic          valid_q;
  logic          seen_q;
  logic          cond;
  logic [HW:0]   hold_eff;

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < N; i++) begin
      pop_d = pop_d + CW'(in_vec[i]);
    end
  end

  // Reserved mode never matches, which also clears any run in progress.
  always_comb begin
    cond = 1'b0;
    case (mode)
      MODE_EXACT:   cond = (cnt1_q == k_target);
      MODE_ATLEAST: cond = (cnt1_q >= k_target);
      MODE_ATMOST:  cond = (cnt1_q <= k_target);
      default:      cond = 1'b0;
    endcase
  end

  always_comb begin
    run_d = '0;
    if (cond) begin
      run_d = (run_q == {HW{1'b1}}) ? run_q : run_q + HW'(1);
    end
    hold_eff = (hold_cycles == '0) ? (HW+1)'(1) : {1'b0, hold_cycles};
    match_d  = cond && ({1'b0, run_d} >= hold_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt1_q  <= '0;
      v1_q    <= 1'b0;
      run_q   <= '0;
      count_q <= '0;
      match_q <= 1'b0;
      valid_q <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      cnt1_q  <= pop_d;
      v1_q    <= in_valid;
      valid_q <= v1_q;
      if (v1_q) begin
        run_q   <= run_d;
        match_q <= match_d;
        count_q <= cnt1_q;
      end
      // A rising match outranks a clear on the same edge.
      if (v1_q && match_d && !match_q) begin
        seen_q <= 1'b1;
      end else if (clear_sticky) begin
        seen_q <= 1'b0;
      end
    end
  end

  assign count_out   = count_q;
  assign match_out   = match_q;
  assign match_valid = valid_q;
  assign match_seen  = seen_q;

endmodule

// File: doc/kofn_persist_detector.md
Name: kofn_persist_detector

Overview:
Parametrised K-of-N vote detector. It counts the active bits in an N-bit input vector and compares the count against a runtime target in one of three modes: exact, at-least or at-most. The match result is qualified by a persistence (debounce) counter, so the output asserts only after the condition holds for a programmable number of consecutive valid samples. It serves as the general replacement for fixed "exactly three of five" voting logic in the Logic_Design library, for redundancy voting and sensor agreement.

Parameters:
N, 5, number of input bits (N >= 2)
CW, $clog2(N+1), width of population count and target
HW, 4, width of persistence threshold and run counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_vec  in  N  vote inputs, sampled when in_valid=1
in_valid  in  1  sample qualifier
k_target  in  CW  target count
mode  in  2  00 exact (cnt==k), 01 at-least (cnt>=k), 10 at-most (cnt<=k), 11 reserved (never matches)
hold_cycles  in  HW  consecutive matching samples required; 0 is treated as 1
clear_sticky  in  1  clears match_seen
count_out  out  CW  registered popcount of last valid sample
match_out  out  1  persistence-qualified match
match_valid  out  1  pulses 1 cycle per valid sample result
match_seen  out  1  sticky flag, set on any match_out 0->1 transition

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset (rst_n=0 at a clk edge) clears all state and outputs to 0: the stage-1 regs, run counter, count_out, match_out, match_valid and match_seen. Reset mid-run discards the run; no partial result emerges afterwards.
- Stage 1 (edge E): cnt1 <= popcount(in_vec) and v1 <= in_valid. in_vec is don't-care when in_valid=0.
- Stage 2 (edge E+1): executes only when v1=1.
  - cond = compare(cnt1, k_target, mode).
  - run_next = cond ? sat(run+1) : 0. run saturates at 2^HW-1 and never wraps.
  - match_out <= cond && (run_next >= hold_eff), where hold_eff = max(hold_cycles, 1). The compare uses HW+1-bit arithmetic.
  - count_out <= cnt1, match_valid <= 1.
- Stage 2 when v1=0: match_valid <= 0. run, match_out and count_out hold. Bubbles neither break nor advance a run.
- Latency: a sample accepted at edge E produces its result after edge E+1 (2 registers). Full throughput: 1 sample per cycle, no backpressure.
- Config timing: k_target, mode and hold_cycles are used combinationally at stage 2, i.e. applied to the sample captured one edge earlier. A mid-run config change applies to the next evaluated sample, and the run counter is not reset.
- match_seen is set at the edge where match_out goes 0->1. clear_sticky=1 clears it. Simultaneous set and clear leaves it set (set wins).
- Boundaries:
  - k_target > N: exact never matches, at-least never matches, at-most always matches.
  - k_target = 0: exact matches only the all-zero vector, and at-least always matches.
  - mode=11 forces cond=0 and resets run.
- Purely synchronous. No combinational path from any input to any output.

Test Plan:
- N=5, mode=00, k=3, hold=1: valid vector 10101 -> after 2 edges count_out=3, match_out=1, match_valid=1. Next vector 11101 -> count_out=4, match_out=0.
- mode=01, k=3: vectors 11110 then 00011 -> match_out 1 (count 4) then 0 (count 2). mode=10, k=3: vector 00011 -> 1.
- hold=3, mode=00, k=3: matches at samples 1, 2 and 3 -> match_out 0, 0, 1. Insert in_valid=0 between samples 2 and 3 -> still asserts on the 3rd valid sample. A non-match at sample 3 -> run=0 and match_out=0.
- Saturation: HW=4, hold=15, 20 consecutive matches -> match_out asserts on the 15th and stays 1. Run holds at 15 with no wrap.
- Sticky: match_out rises while clear_sticky=1 on the same edge -> match_seen=1. clear_sticky alone later -> 0. mode=11 on any vector -> match_out=0.
- Reset: rst_n=0 for 1 edge after 2 of 3 hold matches -> all outputs 0 next cycle. A following single match with hold=3 -> match_out stays 0.
